product_byte_serializer: RTL and testbench
==========================================

// Module: product_byte_serializer
// PURPOSE
//  Downstream stage of the nibble-sequenced 8x8 multiplier. Accepts finished
//  16-bit products over a valid/ready handshake and buffers them in a small FIFO.
//  Streams each product out as bytes over the 8-bit io_out bus.
//  Decouples multiplier throughput from a slow or stalling byte consumer.
// PARAMETERS
//  DATA_W     16  product width; fixed at 2 bytes (values other than 16 are unsupported)
//  DEPTH      4   FIFO depth in words; power of two, 2..16
//  LSB_FIRST  1   1: emit byte [7:0] first; 0: emit byte [15:8] first
// PORTS
//  clk        in   1                 single clock, rising edge
//  rst_n      in   1                 asynchronous, active-low reset
//  flush      in   1                 synchronous clear of FIFO and serializer
//  in_data    in   DATA_W            product from multiplier
//  in_valid   in   1                 in_data valid
//  in_ready   out  1                 FIFO can accept a word
//  out_byte   out  8                 current output byte
//  out_valid  out  1                 out_byte valid
//  out_ready  in   1                 consumer accepts out_byte
//  level      out  $clog2(DEPTH)+1   words held in FIFO (excludes word in serializer)
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - FIFO pointers and level are 0; in_ready=1.
//   - FSM is in IDLE; out_valid=0; out_byte=8'h00.
//  Push: in_valid && in_ready at a rising edge writes in_data at the tail.
//   - in_ready = (level < DEPTH), purely from level.
//   - When full, in_ready is 0 even if a pop occurs in the same cycle.
//   - in_valid while in_ready=0 is ignored; the word is not stored, and no error is flagged.
//  FSM states: IDLE, BYTE0, BYTE1 (+TAG with option).
//   - IDLE: if level>0, pop the head into a 16-bit shift register -> BYTE0.
//   - BYTE0: out_valid=1, out_byte = first byte.
//     out_ready -> BYTE1; else hold, with out_byte stable.
//   - BYTE1: out_valid=1, out_byte = second byte. On out_ready:
//     -> TAG if the option is on;
//     -> otherwise, if level>0, pop the next word -> BYTE0 (no bubble);
//     -> otherwise IDLE.
//  Latency:
//   - A word pushed at edge E into an empty block shows out_valid=1 after edge E+1.
//   - Sustained throughput is 1 byte/cycle when out_ready=1.
//  out_valid and out_byte are registered, with no combinational path from out_ready.
//  Push and pop in the same cycle: level unchanged, pointers both advance.
//  Wrap-around: pointers are modulo DEPTH; level distinguishes full from empty.
//  flush=1 at an edge:
//   - Sets level=0, clears pointers, FSM -> IDLE, out_valid=0.
//   - Discards any word being serialized.
//   - Overrides a concurrent push, which is dropped.
//  Reset asserted mid-word: the output drops immediately (async); no partial resume.
// CONFIGURATION
//  `PBS_XOR_TAG_EN defined:
//   - After BYTE1, the FSM enters TAG with out_byte = hi ^ lo (the fold that
//     io_out shows), out_valid=1.
//   - TAG leaves on out_ready with the same pop/IDLE rule as BYTE1.
//   - Each word emits 3 bytes.
//  Undefined: no TAG state; each word emits 2 bytes.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> out_valid=0, level=0, in_ready=1 immediately.
//  2 Single word: push 16'hA55A with out_ready=1, LSB_FIRST=1.
//    -> 8'h5A then 8'hA5 on consecutive cycles, first valid 1 cycle after push.
//  3 Fill: out_ready=0, push 5 words, DEPTH=4.
//    -> The first word goes to the serializer, level=4, in_ready=0.
//    -> A 6th push is ignored.
//    -> Releasing out_ready drains all 5 words in order with no bubbles.
//  4 Stall: toggle out_ready 1/0 per cycle on 16'h1234.
//    -> out_byte held stable while stalled; sequence is 34,12.
//  5 Flush: flush=1 while in BYTE1 with level=2, plus a concurrent push.
//    -> Next cycle out_valid=0, level=0, and the pushed word is not seen.
//  6 `PBS_XOR_TAG_EN: push 16'hF00F.
//    -> Bytes 0F, F0, FF; push 16'h1111 -> 11, 11, 00.

Source files
------------

// File: rtl/product_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : product_byte_serializer
//  Purpose  : Buffers finished 16-bit multiplier products in a small FIFO and
//             streams each one out as bytes over a valid/ready byte channel.
//             This decouples multiplier throughput from a slow or stalling
//             byte consumer.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1                 rising-edge clock
//    rst_n      in   1                 asynchronous active-low reset
//    flush      in   1                 synchronous clear of FIFO and serializer
//    in_data    in   DATA_W            product word from the multiplier
//    in_valid   in   1                 in_data valid
//    in_ready   out  1                 FIFO can accept a word (level < DEPTH)
//    out_byte   out  8                 current output byte (registered)
//    out_valid  out  1                 out_byte valid (registered)
//    out_ready  in   1                 consumer accepts out_byte
//    level      out  $clog2(DEPTH)+1   words held in the FIFO, excluding the
//                                      word currently being serialized
//  Build option
//    PBS_XOR_TAG_EN : when defined, each word is followed by a third byte
//                     holding hi ^ lo. Undefined: two bytes per word.
// ============================================================================
module product_byte_serializer #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               out_byte,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BYTE0 = 2'd1,
    ST_BYTE1 = 2'd2
`ifdef PBS_XOR_TAG_EN
    , ST_TAG = 2'd3
`endif
  } state_t;

  // --------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;

  // Ready depends on level only, so a full FIFO refuses a word even when a
  // pop happens in the same cycle.
  assign in_ready = (level < FULL_LEVEL);
  assign push     = in_valid && in_ready && !flush;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Serializer
  // --------------------------------------------------------------------------
  state_t            state, state_d;
  logic [DATA_W-1:0] shreg;
  logic [7:0]        out_byte_d;
  logic              out_valid_d;

  function automatic logic [7:0] first_of(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[7:0] : w[15:8];
  endfunction

  function automatic logic [7:0] second_of(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[15:8] : w[7:0];
  endfunction

  // Next-state logic also computes the next output byte so that out_byte and
  // out_valid come straight from flops; out_ready only steers their D inputs.
  always_comb begin
    state_d    = state;
    out_byte_d = out_byte;
    pop        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (level != '0) begin
          pop        = 1'b1;
          state_d    = ST_BYTE0;
          out_byte_d = first_of(head);
        end
      end
      ST_BYTE0: begin
        if (out_ready) begin
          state_d    = ST_BYTE1;
          out_byte_d = second_of(shreg);
        end
      end
`ifdef PBS_XOR_TAG_EN
      ST_BYTE1: begin
        if (out_ready) begin
          state_d    = ST_TAG;
          out_byte_d = shreg[15:8] ^ shreg[7:0];
        end
      end
      ST_TAG: begin
`else
      ST_BYTE1: begin
`endif
        // Last byte of the word: chain straight into the next word when one
        // is waiting so a continuous stream has no idle bubble.
        if (out_ready) begin
          if (level != '0) begin
            pop        = 1'b1;
            state_d    = ST_BYTE0;
            out_byte_d = first_of(head);
          end else begin
            state_d    = ST_IDLE;
            out_byte_d = 8'h00;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        out_byte_d = 8'h00;
      end
    endcase
    if (flush) begin
      pop        = 1'b0;
      state_d    = ST_IDLE;
      out_byte_d = 8'h00;
    end
    out_valid_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      out_byte  <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      out_byte  <= out_byte_d;
      out_valid <= out_valid_d;
      if (pop) shreg <= head;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_product_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_product_byte_serializer
//  Purpose  : Directed self-checking bench for product_byte_serializer
//             (DEPTH=4, LSB_FIRST=1). Tag bytes are expected when
//             PBS_XOR_TAG_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_product_byte_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  product_byte_serializer #(.DATA_W(16), .DEPTH(4), .LSB_FIRST(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    #3;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (out_byte !== 8'h00) begin n_fail++; $display("FAIL reset_out_byte got %h want 00", out_byte); end
    n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    out_ready = 1'b1; in_data = 16'hA55A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || level !== 3'd1) begin n_fail++; $display("FAIL single_after_push valid=%b level=%0d want 0/1", out_valid, level); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_byte !== 8'h5A) begin n_fail++; $display("FAIL single_byte0 got %b/%h want 1/5a", out_valid, out_byte); end
    n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL single_level got %0d want 0", level); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_byte !== 8'hA5) begin n_fail++; $display("FAIL single_byte1 got %b/%h want 1/a5", out_valid, out_byte); end
`ifdef PBS_XOR_TAG_EN
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_byte !== 8'hFF) begin n_fail++; $display("FAIL single_tag got %b/%h want 1/ff", out_valid, out_byte); end
`endif
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b want 0", out_valid); end
  endtask

  task automatic test_fill();
    logic [15:0] words [5];
    logic [7:0]  exp_q [$];
    words[0] = 16'h0100; words[1] = 16'h0302; words[2] = 16'h0504;
    words[3] = 16'h0706; words[4] = 16'h0908;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(words[i][7:0]);
      exp_q.push_back(words[i][15:8]);
`ifdef PBS_XOR_TAG_EN
      exp_q.push_back(words[i][7:0] ^ words[i][15:8]);
`endif
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = words[i]; in_valid = 1'b1;
      tick();
    end
    n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_level got %0d want 4", level); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
    n_tests++; if (out_valid !== 1'b1 || out_byte !== 8'h00) begin n_fail++; $display("FAIL fill_head got %b/%h want 1/00", out_valid, out_byte); end
    in_data = 16'hDEAD;
    tick();
    in_valid = 1'b0;
    n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_sixth_ignored level %0d want 4", level); end
    out_ready = 1'b1;
    foreach (exp_q[i]) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_byte !== exp_q[i]) begin
        n_fail++; $display("FAIL fill_drain[%0d] got %b/%h want 1/%h", i, out_valid, out_byte, exp_q[i]);
      end
      tick();
    end
    n_tests++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL fill_end got %b/%0d want 0/0", out_valid, level); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_data = 16'h1234; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_byte !== 8'h34) begin n_fail++; $display("FAIL stall_b0 got %b/%h want 1/34", out_valid, out_byte); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_byte !== 8'h34) begin n_fail++; $display("FAIL stall_b0_hold got %b/%h want 1/34", out_valid, out_byte); end
    out_ready = 1'b1;
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_byte !== 8'h12) begin n_fail++; $display("FAIL stall_b1 got %b/%h want 1/12", out_valid, out_byte); end
    out_ready = 1'b0;
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_byte !== 8'h12) begin n_fail++; $display("FAIL stall_b1_hold got %b/%h want 1/12", out_valid, out_byte); end
    out_ready = 1'b1;
    tick();
`ifdef PBS_XOR_TAG_EN
    n_tests++; if (out_valid !== 1'b1 || out_byte !== 8'h26) begin n_fail++; $display("FAIL stall_tag got %b/%h want 1/26", out_valid, out_byte); end
    tick();
`endif
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_idle got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hAA11; tick();
    in_data = 16'hBB22; tick();
    in_data = 16'hCC33; tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    n_tests++; if (out_byte !== 8'hAA || level !== 3'd2) begin n_fail++; $display("FAIL flush_setup byte=%h level=%0d want aa/2", out_byte, level); end
    flush = 1'b1; in_valid = 1'b1; in_data = 16'hDD44;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL flush_clear got %b/%0d want 0/0", out_valid, level); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    tick(); tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped_push got %b/%h want 0", out_valid, out_byte); end
    in_valid = 1'b1; in_data = 16'hEE55;
    tick();
    in_valid = 1'b0;
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_byte !== 8'h55) begin n_fail++; $display("FAIL flush_after got %b/%h want 1/55", out_valid, out_byte); end
    tick();
    n_tests++; if (out_byte !== 8'hEE) begin n_fail++; $display("FAIL flush_after_b1 got %h want ee", out_byte); end
`ifdef PBS_XOR_TAG_EN
    tick();
`endif
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after_idle got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midword();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hBEEF; tick();
    in_data = 16'hCAFE; tick();
    in_valid = 1'b0;
    n_tests++; if (out_byte !== 8'hEF || level !== 3'd1) begin n_fail++; $display("FAIL rstmid_setup byte=%h level=%0d want ef/1", out_byte, level); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || out_byte !== 8'h00) begin n_fail++; $display("FAIL rstmid_out got %b/%h want 0/00", out_valid, out_byte); end
    n_tests++; if (level !== 3'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_fifo level=%0d ready=%b want 0/1", level, in_ready); end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick(); tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_resume got %b want 0", out_valid); end
  endtask

`ifdef PBS_XOR_TAG_EN
  task automatic test_xor_tag();
    logic [7:0] exp_b [6];
    exp_b[0] = 8'h0F; exp_b[1] = 8'hF0; exp_b[2] = 8'hFF;
    exp_b[3] = 8'h11; exp_b[4] = 8'h11; exp_b[5] = 8'h00;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'hF00F; tick();
    in_data = 16'h1111; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_byte !== exp_b[i]) begin
        n_fail++; $display("FAIL tag_seq[%0d] got %b/%h want 1/%h", i, out_valid, out_byte, exp_b[i]);
      end
      tick();
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL tag_idle got %b want 0", out_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_fill();
    test_stall();
    test_flush();
    test_reset_midword();
`ifdef PBS_XOR_TAG_EN
    test_xor_tag();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
